// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
//   state_e      : responder FSM states
//   CNT_W        : wait-state counter width
//   BE_*         : the byte-enable patterns the responder accepts
//   be_legal()   : 1 when a byte-enable pattern is one of the accepted ones
//   lane_mask()  : expands a 4-bit byte enable into a 32-bit data mask
package dmem_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  // Naturally aligned byte, halfword and word accesses only.
  localparam logic [3:0] BE_B0 = 4'b0001;
  localparam logic [3:0] BE_B1 = 4'b0010;
  localparam logic [3:0] BE_B2 = 4'b0100;
  localparam logic [3:0] BE_B3 = 4'b1000;
  localparam logic [3:0] BE_HL = 4'b0011;
  localparam logic [3:0] BE_HH = 4'b1100;
  localparam logic [3:0] BE_W  = 4'b1111;

  function automatic logic be_legal(input logic [3:0] be);
    case (be)
      BE_B0, BE_B1, BE_B2, BE_B3, BE_HL, BE_HH, BE_W: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with per-byte-lane write enables.
//   clk      : rising-edge clock
//   we_i     : write strobe, qualified per lane by be_i
//   addr_i   : word index shared by the write and read ports
//   be_i     : byte-lane enables, bit i covers wdata_i[8i+7:8i]
//   wdata_i  : lane-aligned write data
//   rdata_o  : combinational read of the word at addr_i
module dmem_array #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [3:0]        be_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [2**ADDR_W];

  // NOTE: the storage array has no reset branch; clearing it would force it
  // into flops instead of a RAM macro, and software never relies on its
  // power-up contents.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the CPU data interface. Accepts one load/store at a
// time on a valid/ready request channel, waits LATENCY cycles, performs the
// access and presents the result on a valid/ready response channel.
//   clk, Reset_n            : clock, asynchronous active-low reset
//   req_valid / req_ready   : request handshake (ready only when idle)
//   req_we/addr/wdata/be    : store flag, byte address, lane data, byte enables
//   rsp_valid / rsp_ready   : response handshake
//   rsp_rdata / rsp_err     : masked load data (0 for stores/errors), reject flag
//   busy                    : pipeline stall request, high whenever not idle
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        Reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'((LATENCY == 0) ? 0 : LATENCY - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              hold_we_q;
  logic [29:0]       hold_addr_q;
  logic [31:0]       hold_wdata_q;
  logic [3:0]        hold_be_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;

  logic              idle;
  logic              accept;
  logic              acc_fire;
  logic              acc_we;
  logic [29:0]       acc_addr;
  logic [31:0]       acc_wdata;
  logic [3:0]        acc_be;
  logic              acc_err;
  logic              mem_we;
  logic [31:0]       mem_rdata;
  logic [31:0]       rsp_rdata_d;
  logic              unused_addr_lsbs;

  // Byte offset within the word is resolved on the CPU side.
  assign unused_addr_lsbs = ^req_addr[1:0];

  assign idle   = (state_q == IDLE);
  assign accept = req_valid && idle;

  // With zero wait states the access happens on the accept edge, before the
  // hold registers are loaded, so the access operands come straight from the
  // request while idle and from the hold registers otherwise.
  // NOTE: every combinational output gets a value on every path (here via the
  // complete if/else) so no latch is inferred.
  always_comb begin
    if (idle) begin
      acc_we    = req_we;
      acc_addr  = req_addr[31:2];
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end else begin
      acc_we    = hold_we_q;
      acc_addr  = hold_addr_q;
      acc_wdata = hold_wdata_q;
      acc_be    = hold_be_q;
    end
  end

  assign acc_fire = (accept && (LATENCY == 0)) || ((state_q == WAIT) && (cnt_q == '0));
  assign acc_err  = !be_legal(acc_be) || (acc_addr[29:ADDR_W] != '0);
  assign mem_we   = acc_fire && acc_we && !acc_err;

  assign rsp_rdata_d = (acc_err || acc_we) ? '0 : (mem_rdata & lane_mask(acc_be));

  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .addr_i  (acc_addr[ADDR_W-1:0]),
    .be_i    (acc_be),
    .wdata_i (acc_wdata),
    .rdata_o (mem_rdata)
  );

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      hold_we_q    <= 1'b0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      hold_be_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            hold_we_q    <= req_we;
            hold_addr_q  <= req_addr[31:2];
            hold_wdata_q <= req_wdata;
            hold_be_q    <= req_be;
            if (LATENCY == 0) begin
              state_q <= RESP;
            end else begin
              cnt_q   <= LAT_M1;
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) state_q <= RESP;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Response registers load only at the access edge and then hold
      // until the handshake.
      if (acc_fire) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= rsp_rdata_d;
        rsp_err_q   <= acc_err;
      end
    end
  end

  assign req_ready = idle;
  assign busy      = !idle;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states and
// one with none, sharing clock and reset.
module tb_dmem_responder;

  localparam int LAT   = 2;
  localparam int BOUND = 20;

  logic        clk = 1'b0;
  logic        Reset_n;

  logic        req_valid, req_we, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;

  logic        z_req_valid, z_req_we, z_rsp_ready;
  logic [31:0] z_req_addr, z_req_wdata;
  logic [3:0]  z_req_be;
  logic        z_req_ready, z_rsp_valid, z_rsp_err, z_busy;
  logic [31:0] z_rsp_rdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(10), .LATENCY(LAT)) dut (
    .clk(clk), .Reset_n(Reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy)
  );

  dmem_responder #(.ADDR_W(10), .LATENCY(0)) dut_z (
    .clk(clk), .Reset_n(Reset_n),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata),
    .rsp_err(z_rsp_err), .busy(z_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and return just after the edge that accepts it.
  task automatic send(input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be);
    int n = 0;
    req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    req_valid = 1'b1;
    while (!req_ready && n < BOUND) begin
      step();
      n++;
    end
    check("req_ready wait", 32'(n < BOUND), 32'd1);
    step();
    req_valid = 1'b0;
  endtask

  // Count edges after the accept edge until rsp_valid, then check the
  // response; completes the handshake when rsp_ready is high.
  task automatic wait_rsp(input string tag, input logic [31:0] exp_rdata, input logic exp_err);
    int n = 0;
    while (!rsp_valid && n < BOUND) begin
      check({tag, " busy"}, {31'd0, busy}, {31'd0, ~req_ready});
      check({tag, " req_ready low"}, {31'd0, req_ready}, 32'd0);
      step();
      n++;
    end
    check({tag, " latency"}, n, LAT);
    check({tag, " rdata"}, rsp_rdata, exp_rdata);
    check({tag, " err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    if (rsp_ready) begin
      step();
      check({tag, " idle after handshake"}, {31'd0, req_ready}, 32'd1);
    end
  endtask

  initial begin
    Reset_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    rsp_ready = 1'b1;
    z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_req_be = '0;
    z_rsp_ready = 1'b1;
    #12;
    check("reset req_ready", {31'd0, req_ready}, 32'd1);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'd0);
    check("reset rsp_err", {31'd0, rsp_err}, 32'd0);
    Reset_n = 1'b1;
    step();

    // Word store: three non-ready cycles, response on the second edge after accept.
    send(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111);
    wait_rsp("store word", 32'h0, 1'b0);

    // Byte store into lane 2, then full-word and halfword loads.
    send(1'b1, 32'h12, 32'h00AB0000, 4'b0100);
    wait_rsp("store byte", 32'h0, 1'b0);
    send(1'b0, 32'h10, 32'h0, 4'b1111);
    wait_rsp("load word", 32'hDEABBEEF, 1'b0);
    send(1'b0, 32'h10, 32'h0, 4'b0011);
    wait_rsp("load half lo", 32'h0000BEEF, 1'b0);
    send(1'b0, 32'h10, 32'h0, 4'b1100);
    wait_rsp("load half hi", 32'hDEAB0000, 1'b0);

    // Rejected requests leave the array untouched.
    send(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0101);
    wait_rsp("store be 0101", 32'h0, 1'b1);
    send(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000);
    wait_rsp("store be 0000", 32'h0, 1'b1);
    send(1'b0, 32'h10, 32'h0, 4'b1111);
    wait_rsp("load after err", 32'hDEABBEEF, 1'b0);
    send(1'b0, 32'h00001000, 32'h0, 4'b1111);
    wait_rsp("load out of range", 32'h0, 1'b1);

    // Last legal word.
    send(1'b1, 32'h00000FFC, 32'hCAFEF00D, 4'b1111);
    wait_rsp("store top", 32'h0, 1'b0);
    send(1'b0, 32'h00000FFC, 32'h0, 4'b1000);
    wait_rsp("load top byte", 32'hCA000000, 1'b0);

    // Backpressure with a second request already waiting.
    rsp_ready = 1'b0;
    send(1'b0, 32'h10, 32'h0, 4'b1111);
    wait_rsp("bp first", 32'hDEABBEEF, 1'b0);
    req_we = 1'b0; req_addr = 32'h10; req_wdata = 32'h0; req_be = 4'b0011;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp rdata", rsp_rdata, 32'hDEABBEEF);
      check("bp err", {31'd0, rsp_err}, 32'd0);
      check("bp req_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    check("bp idle after release", {31'd0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
    wait_rsp("bp second", 32'h0000BEEF, 1'b0);

    // Reset during WAIT drops the pending store.
    send(1'b1, 32'h20, 32'h55AA55AA, 4'b1111);
    wait_rsp("store 0x20", 32'h0, 1'b0);
    send(1'b1, 32'h20, 32'h11111111, 4'b1111);
    check("mid-wait busy", {31'd0, busy}, 32'd1);
    Reset_n = 1'b0;
    #1;
    check("mid-wait rst req_ready", {31'd0, req_ready}, 32'd1);
    check("mid-wait rst busy", {31'd0, busy}, 32'd0);
    check("mid-wait rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    #1;
    Reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("no rsp after reset", {31'd0, rsp_valid}, 32'd0);
    end
    send(1'b0, 32'h20, 32'h0, 4'b1111);
    wait_rsp("load 0x20 after reset", 32'h55AA55AA, 1'b0);

    // Reset during RESP drops the response but keeps the store.
    rsp_ready = 1'b0;
    send(1'b1, 32'h24, 32'h22222222, 4'b1111);
    wait_rsp("store 0x24", 32'h0, 1'b0);
    Reset_n = 1'b0;
    #1;
    check("resp rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("resp rst busy", {31'd0, busy}, 32'd0);
    #1;
    Reset_n = 1'b1;
    rsp_ready = 1'b1;
    step();
    send(1'b0, 32'h24, 32'h0, 4'b1111);
    wait_rsp("load 0x24", 32'h22222222, 1'b0);

    // Zero wait states: response visible right after the accept edge.
    z_req_we = 1'b1; z_req_addr = 32'h8; z_req_wdata = 32'h12345678; z_req_be = 4'b1111;
    z_req_valid = 1'b1;
    check("lat0 ready before", {31'd0, z_req_ready}, 32'd1);
    step();
    z_req_valid = 1'b0;
    check("lat0 store rsp_valid", {31'd0, z_rsp_valid}, 32'd1);
    check("lat0 store busy", {31'd0, z_busy}, 32'd1);
    check("lat0 store err", {31'd0, z_rsp_err}, 32'd0);
    step();
    check("lat0 idle", {31'd0, z_req_ready}, 32'd1);
    z_req_we = 1'b0; z_req_be = 4'b1000;
    z_req_valid = 1'b1;
    step();
    z_req_valid = 1'b0;
    check("lat0 load rsp_valid", {31'd0, z_rsp_valid}, 32'd1);
    check("lat0 load rdata", z_rsp_rdata, 32'h12000000);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
